// File: rtl/ama_riscv_imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// ama_riscv_imm_gen_pipe_if
// Bundle between the decode front end and the immediate generator.
//   flush     : drop the pending result and the input offered this cycle
//   in_valid  : request valid            in_ready  : generator can accept
//   sel_in    : immediate mode (3 bits)  d_in      : instruction bits [31:7]
//   out_valid : result valid             out_ready : consumer accepts result
//   out_sel   : mode of held result      d_out     : generated immediate
// The producer/consumer side uses the master modport; the generator uses slave.
// ---------------------------------------------------------------------------
interface ama_riscv_imm_gen_pipe_if #(
  parameter int XLEN = 32
) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      sel_in;
  logic [24:0]     d_in;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_sel;
  logic [XLEN-1:0] d_out;

  modport master (
    output flush, in_valid, sel_in, d_in, out_ready,
    input  in_ready, out_valid, out_sel, d_out
  );

  modport slave (
    input  flush, in_valid, sel_in, d_in, out_ready,
    output in_ready, out_valid, out_sel, d_out
  );
endinterface

// File: rtl/ama_riscv_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// ama_riscv_imm_gen_pipe
// Pipelined RISC-V immediate generator with a one-entry registered output.
//   clk : clock
//   rst : synchronous active-low reset
//   bus : ama_riscv_imm_gen_pipe_if.slave (request, result and flush)
// An accepted request produces its immediate one cycle later. A DISABLED
// request re-issues the last generated immediate and its mode.
// ---------------------------------------------------------------------------
module ama_riscv_imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  ama_riscv_imm_gen_pipe_if.slave   bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("ama_riscv_imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    SEL_DISABLED = 3'd0,
    SEL_I        = 3'd1,
    SEL_S        = 3'd2,
    SEL_B        = 3'd3,
    SEL_J        = 3'd4,
    SEL_U        = 3'd5,
    SEL_CSR_Z    = 3'd6,
    SEL_SHAMT    = 3'd7
  } sel_e;

  // Re-index so inst[n] is instruction bit n.
  logic [31:7] inst;
  assign inst = bus.d_in;

  sel_e            sel;
  logic signed [31:0] imm32;
  logic [XLEN-1:0] imm;
  logic            accept;

  logic            out_valid_q;
  logic [XLEN-1:0] d_out_q;
  sel_e            out_sel_q;
  logic [XLEN-1:0] last_imm_q;
  sel_e            last_sel_q;

  assign sel          = sel_e'(bus.sel_in);
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  // Every mode is formed as a 32-bit signed value; zero-extended modes keep
  // bit 31 clear, so one sign-extending cast covers both XLEN choices.
  always_comb begin
    // NOTE: default first so no path leaves imm32 unassigned (no latch).
    imm32 = '0;
    unique case (sel)
      SEL_I:     imm32 = {{20{inst[31]}}, inst[31:20]};
      SEL_S:     imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      SEL_B:     imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                          inst[11:8], 1'b0};
      SEL_J:     imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                          inst[30:21], 1'b0};
      SEL_U:     imm32 = {inst[31:12], 12'b0};
      SEL_CSR_Z: imm32 = {27'b0, inst[19:15]};
      SEL_SHAMT: imm32 = (XLEN == 64) ? {26'b0, inst[25:20]}
                                      : {27'b0, inst[24:20]};
      default:   imm32 = '0;  // DISABLED: value comes from last_imm_q
    endcase
  end

  assign imm = XLEN'(imm32);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      d_out_q     <= '0;
      out_sel_q   <= SEL_I;
      last_imm_q  <= '0;
      last_sel_q  <= SEL_I;
    end else if (bus.flush) begin
      // Flush discards the held result but keeps its data and history.
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      if (sel == SEL_DISABLED) begin
        d_out_q   <= last_imm_q;
        out_sel_q <= last_sel_q;
      end else begin
        d_out_q    <= imm;
        out_sel_q  <= sel;
        last_imm_q <= imm;
        last_sel_q <= sel;
      end
    end else if (bus.out_ready) begin
      // Drain without refill: data stays, only valid drops.
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.d_out     = d_out_q;
  assign bus.out_sel   = out_sel_q;

endmodule
